// File: rtl/loss_batch_buffer.sv
// rtl/loss_batch_buffer.sv - collects sample pairs into a batch vector and holds it until the L1 stage acknowledges
// yHat/y are flat buses; entry i occupies bits [i*(IL+FL) +: IL+FL].
module loss_batch_buffer #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int size  = 16,
    parameter int width = $clog2(size)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IL+FL-1:0]     in_yhat,
    input  logic signed [IL+FL-1:0]     in_y,
    input  logic                        in_last,
    output logic [size*(IL+FL)-1:0]     yHat,
    output logic [size*(IL+FL)-1:0]     y,
    output logic [width-1:0]            num,
    output logic                        en,
    input  logic                        out_ack
);

    localparam int W = IL + FL;
    // Batch length is capped by what num can express and by the vector length.
    localparam int MAX_CNT = (((2 ** width) - 1) < size) ? ((2 ** width) - 1) : size;
    localparam logic [width-1:0] LAST_IDX = width'(MAX_CNT - 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [width-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0]    yhat_q [size];
    logic signed [W-1:0]    yhat_d [size];
    logic signed [W-1:0]    y_q    [size];
    logic signed [W-1:0]    y_d    [size];
    logic                   xfer;
    logic                   close_batch;

    assign xfer        = in_valid && in_ready;
    assign close_batch = in_last || (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (xfer && close_batch) state_d = HOLD;
            HOLD:    if (out_ack)             state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state_q == FILL);
        en       = (state_q == HOLD);
    end

    always_comb begin
        cnt_d  = cnt_q;
        yhat_d = yhat_q;
        y_d    = y_q;
        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < size; i++) begin
                if (cnt_q == i[width-1:0]) begin
                    yhat_d[i] = in_yhat;
                    y_d[i]    = in_y;
                end
            end
        end else if (en && out_ack) begin
            // Clearing on release keeps entries beyond num at zero for the next batch.
            cnt_d = '0;
            for (int i = 0; i < size; i++) begin
                yhat_d[i] = '0;
                y_d[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < size; i++) begin
                yhat_q[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            yhat_q <= yhat_d;
            y_q    <= y_d;
        end
    end

    assign num = cnt_q;

    for (genvar g = 0; g < size; g++) begin : g_flat
        assign yHat[g*W +: W] = yhat_q[g];
        assign y[g*W +: W]    = y_q[g];
    end

endmodule
